// File: rtl/count_sequence_detector.sv
// Detects the valid-sample sequence P0,P1,P2,P3 on a count stream, with overlap
// restart on mismatch, an idle timeout mid-sequence and a saturating detection counter.
module count_sequence_detector #(
    parameter int             W       = 10,
    parameter logic [W-1:0]   P0      = 10'd1,
    parameter logic [W-1:0]   P1      = 10'd11,
    parameter logic [W-1:0]   P2      = 10'd20,
    parameter logic [W-1:0]   P3      = 10'd25,
    parameter int             TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_count_valid,
    input  logic [W-1:0] i_count,
    input  logic         i_clear,
    output logic         o_detected,
    output logic         o_timeout,
    output logic         o_busy,
    output logic [1:0]   o_state,
    output logic [7:0]   o_detect_cnt
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_next_idle;
    logic [W-1:0]  w_expected;
    logic          w_detect;
    logic          w_timeout;
    logic          r_detected;
    logic          r_timeout;
    logic [7:0]    r_detect_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S0;
            r_idle     <= '0;
            r_detected <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_idle     <= w_next_idle;
            r_detected <= w_detect;
            r_timeout  <= w_timeout;
        end
    end

    always_comb begin
        w_expected = P3;
        case (r_state)
            S0:      w_expected = P0;
            S1:      w_expected = P1;
            S2:      w_expected = P2;
            default: w_expected = P3;
        endcase
    end

    // A valid sample always beats the idle timeout, even on the cycle it would expire.
    always_comb begin
        w_next_state = r_state;
        w_next_idle  = r_idle;
        w_detect     = 1'b0;
        w_timeout    = 1'b0;
        if (i_count_valid) begin
            w_next_idle = '0;
            if (i_count == w_expected) begin
                if (r_state == S3) begin
                    w_next_state = S0;
                    w_detect     = 1'b1;
                end else begin
                    w_next_state = state_t'(r_state + 2'd1);
                end
            end else if (i_count == P0) begin
                w_next_state = S1;
            end else begin
                w_next_state = S0;
            end
        end else if (r_state != S0) begin
            if (r_idle == IDLE_LAST) begin
                w_next_state = S0;
                w_next_idle  = '0;
                w_timeout    = 1'b1;
            end else begin
                w_next_idle = r_idle + IW'(1);
            end
        end
    end

    // Clear has priority over a coincident detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_detect_cnt <= 8'd0;
        end else if (i_clear) begin
            r_detect_cnt <= 8'd0;
        end else if (w_detect && (r_detect_cnt != 8'hFF)) begin
            r_detect_cnt <= r_detect_cnt + 8'd1;
        end
    end

    assign o_detected   = r_detected;
    assign o_timeout    = r_timeout;
    assign o_busy       = (r_state != S0);
    assign o_state      = r_state;
    assign o_detect_cnt = r_detect_cnt;

endmodule

// File: doc/count_sequence_detector.md
COUNT_SEQUENCE_DETECTOR -- requirements
Module: count_sequence_detector

Interface
REQ-001 Parameters (name, default, meaning):
- W, 10, data width of incoming count.
- P0, 10'd1, first expected value.
- P1, 10'd11, second expected value.
- P2, 10'd20, third expected value.
- P3, 10'd25, fourth (final) expected value.
- TIMEOUT, 16, max idle cycles between valid samples mid-sequence.
REQ-002 Ports (name, direction, width, meaning):
- i_clk, input, 1, single clock, rising edge.
- i_rst_n, input, 1, reset, asynchronous, active-low.
- i_count_valid, input, 1, qualifies i_count for one cycle.
- i_count, input, W, count sample from the generator side.
- i_clear, input, 1, synchronous clear of the detection counter.
- o_detected, output, 1, one-cycle pulse on full-sequence match.
- o_timeout, output, 1, one-cycle pulse when a partial sequence is abandoned due to idle.
- o_busy, output, 1, high while a partial match is in progress.
- o_state, output, 2, current match index (0..3).
- o_detect_cnt, output, 8, number of detections, saturating.

Function
REQ-003 Samples SHALL be consumed only on rising i_clk edges with i_count_valid=1; i_count SHALL be ignored otherwise.
REQ-004 The FSM SHALL have states S0, S1, S2, S3, where Sn means that n values have matched; o_state SHALL equal n.
REQ-005 Valid sample in Sn, n<3, equal to P[n] -> S(n+1).
REQ-006 Valid sample in S3 equal to P3 -> S0, with o_detected=1 in the following cycle (registered, 1-cycle latency).
REQ-007 Valid sample mismatching P[n] in any state -> S1 if sample==P0, else S0 (restart overlap).
REQ-008 In S0, a valid sample ==P0 -> S1; any other value -> stay in S0.
REQ-009 An idle counter SHALL reset to 0 on every valid sample and increment each cycle with no valid sample while state!=S0.
REQ-010 When the idle counter reaches TIMEOUT in state!=S0, the FSM SHALL go to S0, o_timeout SHALL pulse for 1 cycle, and the idle counter SHALL clear.
REQ-011 A valid sample arriving in the same cycle the idle counter would reach TIMEOUT SHALL take priority; no timeout occurs.
REQ-012 o_busy SHALL be 1 exactly when state!=S0 (combinational from state).
REQ-013 o_detect_cnt SHALL increment by 1 on each detection and saturate at 8'hFF.
REQ-014 i_clear=1 SHALL set o_detect_cnt to 0 next cycle; FSM unaffected.
REQ-015 If i_clear and a detection coincide, the clear SHALL win: count=0 and o_detected still pulses.
REQ-016 o_detected and o_timeout SHALL never both be 1 in the same cycle.

Reset
REQ-017 i_rst_n=0 SHALL immediately (asynchronously) force state=S0, idle counter=0, o_detected=0, o_timeout=0, o_busy=0, o_state=0, o_detect_cnt=0.
REQ-018 Reset asserted mid-sequence SHALL discard the partial match; after release, detection SHALL require a fresh P0..P3.
REQ-019 Release of i_rst_n SHALL be treated as synchronous to i_clk; the first sample is accepted on the first rising edge after release.

Verification
REQ-020 Sequence valid samples 1,11,20,25 on consecutive cycles -> o_state 1,2,3,0; o_detected pulses once the cycle after 25; o_detect_cnt=1.
REQ-021 Samples 1,11,1,11,20,25 -> state 1,2,1,2,3,0; exactly one o_detected pulse.
REQ-022 Samples 1,11 then 16 idle cycles -> o_timeout pulses once, o_state=0, o_busy=0, no detection.
REQ-023 Samples 1,11,20, then i_rst_n low for 2 cycles mid-clock, then 25 -> no detection; all outputs 0 during reset.
REQ-024 300 back-to-back full sequences -> o_detect_cnt saturates at 255; i_clear then -> o_detect_cnt=0.
REQ-025 Samples 1,11,20 with valid deasserted for 4 cycles between each -> detection still occurs when 25 arrives (no timeout).
